freq_meter: RTL and testbench
=============================

# freq_meter

Measures an incoming square wave, such as the `outClk` of a clock divider or an external pin, against the system clock. Every gate window it reports the signal frequency in Hz. Every cycle of the signal it reports the period and high time in system-clock cycles. It is the receiving end of the clock-divider path: the divider turns a `speed` value into a clock, and this block turns a clock back into a `speed` value, so frequency uses the divider's `speed` width.

## Interface
- `BASE_SPEED`, 50000000, system clock frequency in Hz.
- `GATE_DIV`, 10. Gate window length `GATE_LEN` = `BASE_SPEED/GATE_DIV` cycles. Frequency = edge count × `GATE_DIV`.
- Derived width: `W` = `$clog2(BASE_SPEED)+1`.
- `clk`  in  1  system clock; all logic on posedge.
- `reset_n`  in  1  synchronous, active-low reset.
- `sig_in`  in  1  measured signal, asynchronous to `clk`.
- `freq`  out  `W`  last measured frequency in Hz; holds between updates.
- `freq_valid`  out  1  one-cycle pulse when `freq` updates.
- `period`  out  `W`  clk cycles between the last two rising edges.
- `high_time`  out  `W`  clk cycles `sig_in` was high in that period.
- `period_valid`  out  1  one-cycle pulse when `period`/`high_time` update.
- `no_signal`  out  1  high while no rising edge has been seen for `BASE_SPEED` cycles.

## Operation
- Input path:
  - `sig_in` passes through a 2-flop synchronizer giving `sig_s`, then a delay flop giving `sig_d`.
  - `rise` = `sig_s & ~sig_d`; `fall` = `~sig_s & sig_d`.
  - All synchronizer flops reset to 0.
  - An `armed` bit sets 3 cycles after reset release. `rise`/`fall` are masked until then, so a high input at reset release does not count as an edge.
- Gate counter (free-running, independent of the FSM):
  - `gate_cnt` counts 0..`GATE_LEN`-1 and wraps.
  - `edge_cnt` increments on each `rise`.
  - On the cycle `gate_cnt`=`GATE_LEN`-1: `freq` <= (`edge_cnt` + `rise`) × `GATE_DIV`, `freq_valid` pulses, and `edge_cnt` <= 0.
  - A rise on the last gate cycle counts toward the ending window.
- Period FSM, with states IDLE, HIGH, LOW:
  - IDLE: wait for `rise`, then go to HIGH with `cnt` <= 1.
  - HIGH: `cnt`++ each cycle. On `fall`: `high_time_r` <= `cnt`, go to LOW.
  - LOW: `cnt`++ each cycle. On `rise`: `period` <= `cnt`, `high_time` <= `high_time_r`, `period_valid` pulses, `cnt` <= 1, go to HIGH.
  - The first period after IDLE is reported normally; a partial high phase at startup is never reported.
- Timeout:
  - In HIGH or LOW, if `cnt` reaches `BASE_SPEED` with no `rise`: go to IDLE, `period` <= 0, `high_time` <= 0, `no_signal` <= 1. No `period_valid`.
  - If `rise` and timeout coincide, `rise` wins.
  - `no_signal` clears on the next `rise`.
- Width rules:
  - `cnt` never exceeds `BASE_SPEED`, so it fits in `W`.
  - `edge_cnt` never exceeds `GATE_LEN`/2, so `freq` ≤ `BASE_SPEED`/2 and never overflows `W`.

## Timing
- Reset (`reset_n`=0 at a clk edge):
  - `freq`, `period`, `high_time`, `freq_valid`, `period_valid` = 0; `no_signal` = 0.
  - FSM = IDLE; `gate_cnt` = `edge_cnt` = `cnt` = 0; `armed` = 0.
- Reset mid-operation discards all partial counts. The next `freq_valid` comes `GATE_LEN` cycles after release.
- Latency:
  - `rise` is true in the 3rd cycle after `sig_in` is first sampled high.
  - `period_valid` and `freq` updates are registered, so they are visible the cycle after the qualifying event.
- Pulses last exactly one cycle; back-to-back pulses are legal only for `period_valid`, at a 2-cycle period.
- Minimum resolvable phase: 1 high cycle and 1 low cycle, i.e. `sig_in` period ≥ 2 clk. Faster inputs alias; this is undefined, not detected.

## Structure
- Package `freq_meter_pkg` holds the FSM state enum (IDLE, HIGH, LOW) and the `W`/`GATE_LEN` derivation function.
- Sub-module `sync_edge`: 2-flop synchronizer plus delay flop, with `rise`/`fall` outputs and reset-to-0 behavior. It is reusable for the buttons and switches on the same board.

## Test plan
- `BASE_SPEED`=1000, `GATE_DIV`=10, `sig_in` period 10 (5 high, 5 low) -> every 100 cycles `freq`=100 with `freq_valid` pulse; from the 2nd period on, `period`=10, `high_time`=5.
- Duty 3/7 (period 10, high 3) -> `period`=10, `high_time`=3; `freq` still 100.
- `sig_in` held high through reset release -> no rise counted; first `freq` = 0; FSM stays IDLE.
- Signal stops after 4 periods -> 1000 cycles after last rise `no_signal`=1 and `period`=`high_time`=0; a new rise clears `no_signal` and the following full period reports correctly.
- Rise placed exactly on the cycle `gate_cnt`=99 -> counted in the ending window (`freq` includes it); the next window starts at 0.
- `reset_n` pulsed low for 1 cycle mid-period -> all outputs 0 the next cycle; measurement resumes and yields correct `period` after 2 full signal periods.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and width helpers for the frequency/period meter.
// The counter width W is derived from the system clock rate so the same formula serves the divider path.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } periodState_e;

    // Edges are ignored until the synchronizer has flushed its reset contents.
    localparam logic [1:0] ARM_DONE = 2'd3;

    function automatic int calcWidth(input int baseSpeed);
        return $clog2(baseSpeed) + 1;
    endfunction

    function automatic int calcGateLen(input int baseSpeed, input int gateDiv);
        return baseSpeed / gateDiv;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus delay flop with masked rise/fall strobes.
// Reusable for any asynchronous level input such as buttons, switches or clock pins.
module sync_edge
    import freq_meter_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic data_i,
    output logic rise_o,
    output logic fall_o
);

    logic       meta_q;
    logic       sync_q;
    logic       delay_q;
    logic [1:0] armCnt_q;
    logic       armed;

    // A level already high at reset release must not look like an edge, so
    // strobes stay masked until every flop holds real input history.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            delay_q  <= 1'b0;
            armCnt_q <= 2'd0;
        end else begin
            meta_q  <= data_i;
            sync_q  <= meta_q;
            delay_q <= sync_q;
            if (armCnt_q != ARM_DONE) begin
                armCnt_q <= armCnt_q + 2'd1;
            end
        end
    end

    assign armed  = (armCnt_q == ARM_DONE);
    assign rise_o = armed &  sync_q & ~delay_q;
    assign fall_o = armed & ~sync_q &  delay_q;

endmodule

// File: rtl/freq_meter.sv
// Measures an asynchronous square wave: frequency in Hz per gate window, and
// period/high time in system-clock cycles per signal cycle, with a loss-of-signal flag.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int  BASE_SPEED = 50000000,
    parameter int  GATE_DIV   = 10,
    localparam int W          = calcWidth(BASE_SPEED)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         sig_in,
    output logic [W-1:0] freq,
    output logic         freq_valid,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         period_valid,
    output logic         no_signal
);

    localparam int         GATE_LEN  = calcGateLen(BASE_SPEED, GATE_DIV);
    localparam logic [W-1:0] GATE_LAST = W'(GATE_LEN - 1);
    localparam logic [W-1:0] DIV_W     = W'(GATE_DIV);
    localparam logic [W-1:0] CNT_MAX   = W'(BASE_SPEED);
    localparam logic [W-1:0] ONE_W     = W'(1);

    logic sigRise;
    logic sigFall;

    sync_edge u_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .data_i  (sig_in),
        .rise_o  (sigRise),
        .fall_o  (sigFall)
    );

    logic [W-1:0] gateCnt_q,   gateCnt_d;
    logic [W-1:0] edgeCnt_q,   edgeCnt_d;
    logic [W-1:0] freq_q,      freq_d;
    logic         freqValid_q, freqValid_d;

    // A rise on the final gate cycle belongs to the window that is closing.
    always_comb begin
        gateCnt_d   = gateCnt_q + ONE_W;
        edgeCnt_d   = edgeCnt_q + {{(W-1){1'b0}}, sigRise};
        freq_d      = freq_q;
        freqValid_d = 1'b0;
        if (gateCnt_q == GATE_LAST) begin
            gateCnt_d   = '0;
            edgeCnt_d   = '0;
            freq_d      = W'((edgeCnt_q + {{(W-1){1'b0}}, sigRise}) * DIV_W);
            freqValid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gateCnt_q   <= '0;
            edgeCnt_q   <= '0;
            freq_q      <= '0;
            freqValid_q <= 1'b0;
        end else begin
            gateCnt_q   <= gateCnt_d;
            edgeCnt_q   <= edgeCnt_d;
            freq_q      <= freq_d;
            freqValid_q <= freqValid_d;
        end
    end

    periodState_e state_q,       state_d;
    logic [W-1:0] cnt_q,         cnt_d;
    logic [W-1:0] highTimeR_q,   highTimeR_d;
    logic [W-1:0] period_q,      period_d;
    logic [W-1:0] highTime_q,    highTime_d;
    logic         periodValid_q, periodValid_d;
    logic         noSignal_q,    noSignal_d;
    logic         timeout;

    // A pending rise always beats the timeout on the same cycle.
    assign timeout = (cnt_q == CNT_MAX) && !sigRise;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        highTimeR_d   = highTimeR_q;
        period_d      = period_q;
        highTime_d    = highTime_q;
        periodValid_d = 1'b0;
        noSignal_d    = noSignal_q;

        if (sigRise) begin
            noSignal_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (sigRise) begin
                    state_d = HIGH;
                    cnt_d   = ONE_W;
                end
            end
            HIGH: begin
                if (timeout) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    period_d   = '0;
                    highTime_d = '0;
                    noSignal_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE_W;
                    if (sigFall) begin
                        highTimeR_d = cnt_q;
                        state_d     = LOW;
                    end
                end
            end
            LOW: begin
                if (sigRise) begin
                    period_d      = cnt_q;
                    highTime_d    = highTimeR_q;
                    periodValid_d = 1'b1;
                    cnt_d         = ONE_W;
                    state_d       = HIGH;
                end else if (timeout) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    period_d   = '0;
                    highTime_d = '0;
                    noSignal_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE_W;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            highTimeR_q   <= '0;
            period_q      <= '0;
            highTime_q    <= '0;
            periodValid_q <= 1'b0;
            noSignal_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            highTimeR_q   <= highTimeR_d;
            period_q      <= period_d;
            highTime_q    <= highTime_d;
            periodValid_q <= periodValid_d;
            noSignal_q    <= noSignal_d;
        end
    end

    assign freq         = freq_q;
    assign freq_valid   = freqValid_q;
    assign period       = period_q;
    assign high_time    = highTime_q;
    assign period_valid = periodValid_q;
    assign no_signal    = noSignal_q;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter with a small clock (1000 Hz, 100-cycle gate).
// The reference model tracks rising/falling edge times and derives every output from them.
module tb_freq_meter;

    localparam int BASE_SPEED = 1000;
    localparam int GATE_DIV   = 10;
    localparam int GATE_LEN   = BASE_SPEED / GATE_DIV;
    localparam int W          = $clog2(BASE_SPEED) + 1;

    logic         clk;
    logic         resetN;
    logic         sigIn;
    logic [W-1:0] freq;
    logic         freqValid;
    logic [W-1:0] period;
    logic [W-1:0] highTime;
    logic         periodValid;
    logic         noSignal;

    freq_meter #(
        .BASE_SPEED (BASE_SPEED),
        .GATE_DIV   (GATE_DIV)
    ) dut (
        .clk          (clk),
        .reset_n      (resetN),
        .sig_in       (sigIn),
        .freq         (freq),
        .freq_valid   (freqValid),
        .period       (period),
        .high_time    (highTime),
        .period_valid (periodValid),
        .no_signal    (noSignal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    // Reference model: edges since reset release, input history, edge bookkeeping.
    int nEdge;
    bit sHist[$];
    int winRises;
    bit tracking;
    bit fallSeen;
    int lastRise;
    int lastFall;
    int expFreq;
    bit expFreqValid;
    int expPeriod;
    int expHigh;
    bit expPeriodValid;
    bit expNoSignal;

    // The meter sees the input two cycles late and ignores edges until it has settled.
    task automatic updateModel();
        bit riseE;
        bit fallE;
        if (!resetN) begin
            nEdge = 0;
            sHist.delete();
            winRises = 0;
            tracking = 0;
            fallSeen = 0;
            lastRise = 0;
            lastFall = 0;
            expFreq = 0;
            expFreqValid = 0;
            expPeriod = 0;
            expHigh = 0;
            expPeriodValid = 0;
            expNoSignal = 0;
            return;
        end
        sHist.push_back(sigIn);
        riseE = (nEdge >= 3) && sHist[nEdge-2] && !sHist[nEdge-3];
        fallE = (nEdge >= 3) && !sHist[nEdge-2] && sHist[nEdge-3];
        expFreqValid = 0;
        expPeriodValid = 0;
        if (nEdge % GATE_LEN == GATE_LEN - 1) begin
            expFreq = (winRises + int'(riseE)) * GATE_DIV;
            expFreqValid = 1;
            winRises = 0;
        end else begin
            winRises += int'(riseE);
        end
        if (riseE) begin
            if (tracking && fallSeen) begin
                expPeriod = nEdge - lastRise;
                expHigh = lastFall - lastRise;
                expPeriodValid = 1;
            end
            tracking = 1;
            fallSeen = 0;
            lastRise = nEdge;
            expNoSignal = 0;
        end else if (tracking && (nEdge - lastRise == BASE_SPEED)) begin
            tracking = 0;
            expPeriod = 0;
            expHigh = 0;
            expNoSignal = 1;
        end else if (tracking && fallE && !fallSeen) begin
            fallSeen = 1;
            lastFall = nEdge;
        end
        nEdge++;
    endtask

    task automatic checkOne(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s at edge %0d: observed %0d expected %0d", tag, nEdge, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkOne("freq", freq, W'(expFreq));
        checkOne("freq_valid", W'(freqValid), W'(expFreqValid));
        checkOne("period", period, W'(expPeriod));
        checkOne("high_time", highTime, W'(expHigh));
        checkOne("period_valid", W'(periodValid), W'(expPeriodValid));
        checkOne("no_signal", W'(noSignal), W'(expNoSignal));
    endtask

    task automatic stepCycle();
        @(posedge clk);
        updateModel();
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus(input logic level, input int cycles);
        sigIn = level;
        repeat (cycles) stepCycle();
    endtask

    task automatic applyPeriods(input int highLen, input int lowLen, input int count);
        repeat (count) begin
            applyStimulus(1'b1, highLen);
            applyStimulus(1'b0, lowLen);
        end
    endtask

    initial begin
        resetN = 1'b0;
        sigIn  = 1'b0;
        nEdge  = 0;
        repeat (3) stepCycle();
        resetN = 1'b1;

        $display("[TB] 50%% duty, period 10");
        applyPeriods(5, 5, 30);

        $display("[TB] 30%% duty, period 10");
        applyPeriods(3, 7, 25);

        $display("[TB] input high through reset release");
        sigIn  = 1'b1;
        resetN = 1'b0;
        repeat (2) stepCycle();
        resetN = 1'b1;
        applyStimulus(1'b1, 150);
        applyStimulus(1'b0, 10);

        $display("[TB] signal stops after four periods");
        applyPeriods(5, 5, 4);
        applyStimulus(1'b0, 1100);
        applyPeriods(5, 5, 3);

        $display("[TB] rise on the last gate cycle");
        sigIn = 1'b0;
        stepCycle();
        stepCycle();
        while (nEdge % GATE_LEN != GATE_LEN - 3) stepCycle();
        applyPeriods(5, 5, 12);

        $display("[TB] one-cycle reset mid-period");
        applyStimulus(1'b1, 2);
        resetN = 1'b0;
        stepCycle();
        resetN = 1'b1;
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 5);
        applyPeriods(5, 5, 6);

        $display("[TB] randomized phases");
        for (int seg = 0; seg < 150; seg++) begin
            applyStimulus(1'b1, int'($urandom_range(1, 8)));
            if (seg == 75) begin
                applyStimulus(1'b0, 1020);
            end else begin
                applyStimulus(1'b0, int'($urandom_range(1, 8)));
            end
        end
        applyStimulus(1'b0, 120);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
